cbx_param_dbuf: RTL and testbench
=================================

// Module: cbx_param_dbuf
// PURPOSE
//  Parametrised X-direction connection block with a double-buffered configuration chain.
//  - Left/right channel tracks pass straight through.
//  - Each of NUM_IPIN grid pins gets a MUX_SIZE:1 routing mux over left/right track pairs.
//  - Configuration shifts into a shadow chain and is applied atomically on commit.
//  - Routing stays glitch-free while a new bitstream streams through the ccff daisy chain.
// PARAMETERS
//  CHAN_W        9   tracks per direction (chanx_*_in/out width)
//  NUM_IPIN      10  number of pin muxes / ipin_out width
//  MUX_SIZE      6   inputs per pin mux; even, 2..2*CHAN_W
//  TRACK_STRIDE  4   track offset between successive input pairs of one mux
//  SEL_W    $clog2(MUX_SIZE)  select bits per mux (localparam)
//  CFG_BITS NUM_IPIN*SEL_W    shadow/active chain length (localparam)
// PORTS
//  prog_clk         in   1         configuration clock (only clock)
//  prog_reset       in   1         asynchronous, active-high reset
//  ccff_head        in   1         serial config data in
//  ccff_en          in   1         shift enable: one bit per prog_clk while high
//  ccff_commit      in   1         copy shadow chain to active config
//  chanx_left_in    in   CHAN_W    tracks entering from the left
//  chanx_right_in   in   CHAN_W    tracks entering from the right
//  chanx_left_out   out  CHAN_W    = chanx_right_in (combinational)
//  chanx_right_out  out  CHAN_W    = chanx_left_in (combinational)
//  ipin_out         out  NUM_IPIN  routed grid pin signals
//  ccff_tail        out  1         serial config out to next block = shadow[CFG_BITS-1]
//  cfg_valid        out  1         active config loaded at least once since reset
//  cfg_err          out  1         1-cycle pulse on a rejected commit
//  sel_err          out  1         any active select >= MUX_SIZE (only when cfg_valid)
// BEHAVIOUR
//  Reset (async on prog_reset=1):
//  - Clears shadow, active, bit counter, cfg_valid and cfg_err.
//  - Outputs go to 0 immediately: ccff_tail, ipin_out, sel_err.
//  - Pass-through channel outputs are unaffected.
//  Shift:
//  - When ccff_en=1 at a prog_clk edge: shadow <= {shadow[CFG_BITS-2:0], ccff_head}.
//  - cnt increments and saturates at CFG_BITS; further shifts are legal daisy-chain traffic.
//  - After CFG_BITS shifts, the first bit shifted in sits in shadow[CFG_BITS-1].
//  - It emerges on ccff_tail, delayed CFG_BITS shifts from entry.
//  Field map:
//  - Mux k select = active[k*SEL_W +: SEL_W], LSB first.
//  - The highest-index mux's MSB is the first bit shifted in.
//  Mux input i (0..MUX_SIZE-1):
//  - pair j = i/2; track t = (k + j*TRACK_STRIDE) % CHAN_W.
//  - Even i selects chanx_left_in[t]; odd i selects chanx_right_in[t].
//  - Select >= MUX_SIZE forces ipin_out[k]=0 and asserts sel_err.
//  Commit (sampled at a prog_clk edge):
//  - Accepted only if cnt==CFG_BITS and ccff_en=0 in the same cycle.
//  - Accept: active <= shadow, cnt <= 0, cfg_valid <= 1.
//  - Shadow is retained and ccff_tail is unchanged.
//  - Reject (cnt<CFG_BITS or ccff_en=1): active unchanged and cfg_err=1 for exactly one cycle.
//  - On reject, any requested shift still occurs.
//  - A held ccff_commit re-evaluates every cycle; the second cycle rejects because cnt=0.
//  Outputs and latency:
//  - ipin_out is combinational from active and the channel inputs.
//  - ipin_out is 0 for all k while cfg_valid=0.
//  - New routing appears right after the accepting edge (1-cycle commit latency).
//  - While shifting, ipin_out keeps following the old active config; no intermediate values.
//  - Reset mid-shift or mid-commit aborts the load; the full load must be restarted.
// TESTING (defaults: SEL_W=3, CFG_BITS=30)
//  1 Reset release:
//    - stimulus: drive chanx_left_in=9'h1A5.
//    - required: chanx_right_out=9'h1A5; ipin_out=0, cfg_valid=0, ccff_tail=0.
//  2 Load and commit:
//    - stimulus: shift 30 bits with mux0 sel=3 and all others sel=0; commit.
//    - required: next cycle cfg_valid=1.
//    - required: ipin_out[0] tracks chanx_right_in[4].
//    - required: ipin_out[5] tracks chanx_left_in[5].
//  3 Short commit:
//    - stimulus: commit after 29 shifts.
//    - required: cfg_err high for 1 cycle; active and ipin_out unchanged.
//    - required: one more shift then commit is accepted.
//  4 Glitch-free reprogram:
//    - stimulus: with config A active, shift 30 bits of config B.
//    - required: ipin_out follows A on every cycle until the commit edge, then follows B.
//  5 Illegal select:
//    - stimulus: mux2 sel=7; commit.
//    - required: ipin_out[2]=0 and sel_err=1.
//    - stimulus: reload with sel=2.
//    - required: sel_err=0, ipin_out[2]=chanx_left_in[6].
//  6 Daisy chain and reset:
//    - stimulus: pattern 1,0,0,... shifted in.
//    - required: ccff_tail=1 on cycle 30 of shifting.
//    - stimulus: prog_reset asserted mid-shift.
//    - required: immediate clear of all state and outputs.

Source files
------------

// File: rtl/cbx_param_dbuf.sv
// X-direction connection block: straight-through channel tracks plus one routing mux
// per grid pin, configured through a double-buffered (shadow/active) ccff chain.
module cbx_param_dbuf #(
    parameter int CHAN_W       = 9,
    parameter int NUM_IPIN     = 10,
    parameter int MUX_SIZE     = 6,
    parameter int TRACK_STRIDE = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              ccff_commit,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [CHAN_W-1:0] chanx_right_in,
    output logic [CHAN_W-1:0] chanx_left_out,
    output logic [CHAN_W-1:0] chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic              ccff_tail,
    output logic              cfg_valid,
    output logic              cfg_err,
    output logic              sel_err
);
    localparam int SEL_W    = $clog2(MUX_SIZE);
    localparam int CFG_BITS = NUM_IPIN * SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(MUX_SIZE);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                cfg_err_q, cfg_err_d;
    logic                commit_ok;
    logic [NUM_IPIN-1:0] sel_bad;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            shadow_q    <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // The commit copies the pre-shift shadow; a shift in the same cycle forces a reject anyway.
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        cfg_valid_d = cfg_valid_q;
        cfg_err_d   = 1'b0;
        commit_ok   = ccff_commit && !ccff_en && (cnt_q == CNT_FULL);
        if (ccff_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (ccff_commit) begin
            if (commit_ok) begin
                active_d    = shadow_q;
                cnt_d       = '0;
                cfg_valid_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;
    assign ccff_tail       = shadow_q[CFG_BITS-1];
    assign cfg_valid       = cfg_valid_q;
    assign cfg_err         = cfg_err_q;
    assign sel_err         = cfg_valid_q & (|sel_bad);

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
            // Padded to a power of two so out-of-range selects land on constant zero.
            logic [(1 << SEL_W)-1:0] mux_in;
            logic [SEL_W-1:0]        sel;

            assign sel = active_q[gi*SEL_W +: SEL_W];

            for (gj = 0; gj < (1 << SEL_W); gj++) begin : g_in
                if (gj < MUX_SIZE) begin : g_track
                    localparam int TRK = (gi + (gj / 2) * TRACK_STRIDE) % CHAN_W;
                    if (gj % 2 == 0) begin : g_left
                        assign mux_in[gj] = chanx_left_in[TRK];
                    end else begin : g_right
                        assign mux_in[gj] = chanx_right_in[TRK];
                    end
                end else begin : g_pad
                    assign mux_in[gj] = 1'b0;
                end
            end

            assign sel_bad[gi]  = ({1'b0, sel} >= SEL_LIM);
            assign ipin_out[gi] = cfg_valid_q & mux_in[sel];
        end
    endgenerate
endmodule

// File: tb/tb_cbx_param_dbuf.sv
// Randomized bench for cbx_param_dbuf against a behavioural model of the
// shadow/active configuration and pin routing rules.
module tb_cbx_param_dbuf;
    localparam int CW = 9;
    localparam int NP = 10;
    localparam int MS = 6;
    localparam int ST = 4;
    localparam int SW = 3;
    localparam int CB = 30;

    logic          clk = 1'b0;
    logic          prog_reset;
    logic          ccff_head, ccff_en, ccff_commit;
    logic [CW-1:0] chanx_left_in, chanx_right_in;
    logic [CW-1:0] chanx_left_out, chanx_right_out;
    logic [NP-1:0] ipin_out;
    logic          ccff_tail, cfg_valid, cfg_err, sel_err;

    int total = 0;
    int bad   = 0;

    logic [CB-1:0] mshadow;
    int            msel [NP];
    int            mcnt;
    logic          mvalid, merr;
    int            wsel [NP];
    logic [CB-1:0] w;

    always #5 clk = ~clk;

    cbx_param_dbuf #(
        .CHAN_W(CW), .NUM_IPIN(NP), .MUX_SIZE(MS), .TRACK_STRIDE(ST)
    ) dut (
        .prog_clk        (clk),
        .prog_reset      (prog_reset),
        .ccff_head       (ccff_head),
        .ccff_en         (ccff_en),
        .ccff_commit     (ccff_commit),
        .chanx_left_in   (chanx_left_in),
        .chanx_right_in  (chanx_right_in),
        .chanx_left_out  (chanx_left_out),
        .chanx_right_out (chanx_right_out),
        .ipin_out        (ipin_out),
        .ccff_tail       (ccff_tail),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err),
        .sel_err         (sel_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NP-1:0] model_ipin();
        logic [NP-1:0] v;
        int t;
        v = '0;
        for (int k = 0; k < NP; k++) begin
            if (mvalid && msel[k] < MS) begin
                t = (k + (msel[k] / 2) * ST) % CW;
                v[k] = (msel[k] % 2 == 1) ? chanx_right_in[t] : chanx_left_in[t];
            end
        end
        return v;
    endfunction

    function automatic logic model_sel_err();
        logic e;
        e = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (msel[k] >= MS) e = 1'b1;
        end
        return mvalid & e;
    endfunction

    task automatic model_update();
        logic [CB-1:0] pre;
        logic ok;
        if (prog_reset) begin
            mshadow = '0;
            for (int k = 0; k < NP; k++) msel[k] = 0;
            mcnt   = 0;
            mvalid = 1'b0;
            merr   = 1'b0;
        end else begin
            pre  = mshadow;
            ok   = ccff_commit && !ccff_en && (mcnt == CB);
            merr = 1'b0;
            if (ccff_en) begin
                mshadow = {mshadow[CB-2:0], ccff_head};
                if (mcnt < CB) mcnt++;
            end
            if (ccff_commit) begin
                if (ok) begin
                    for (int k = 0; k < NP; k++) msel[k] = int'(pre[k*SW +: SW]);
                    mcnt   = 0;
                    mvalid = 1'b1;
                end else begin
                    merr = 1'b1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("left_out",  32'(chanx_left_out),  32'(chanx_right_in));
        chk("right_out", 32'(chanx_right_out), 32'(chanx_left_in));
        chk("ipin_out",  32'(ipin_out),        32'(model_ipin()));
        chk("ccff_tail", 32'(ccff_tail),       32'(mshadow[CB-1]));
        chk("cfg_valid", 32'(cfg_valid),       32'(mvalid));
        chk("cfg_err",   32'(cfg_err),         32'(merr));
        chk("sel_err",   32'(sel_err),         32'(model_sel_err()));
    endtask

    task automatic step(input logic h, input logic en, input logic cm);
        @(negedge clk);
        ccff_head      = h;
        ccff_en        = en;
        ccff_commit    = cm;
        chanx_left_in  = CW'($urandom);
        chanx_right_in = CW'($urandom);
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    function automatic logic [CB-1:0] pack_w();
        logic [CB-1:0] r;
        r = '0;
        for (int k = 0; k < NP; k++) r[k*SW +: SW] = SW'(wsel[k]);
        return r;
    endfunction

    task automatic load(input logic [CB-1:0] word);
        $display("load cfg=%h", word);
        for (int i = CB - 1; i >= 0; i--) step(word[i], 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        prog_reset = 1'b1;
        ccff_head = 1'b0; ccff_en = 1'b0; ccff_commit = 1'b0;
        chanx_left_in = '0; chanx_right_in = '0;
        mshadow = '0; mcnt = 0; mvalid = 1'b0; merr = 1'b0;
        for (int k = 0; k < NP; k++) begin msel[k] = 0; wsel[k] = 0; end
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // reset release
        prog_reset    = 1'b0;
        chanx_left_in = 9'h1A5;
        #1;
        chk("t1_right_out", 32'(chanx_right_out), 32'h1A5);
        chk("t1_ipin",      32'(ipin_out),        32'h0);
        chk("t1_valid",     32'(cfg_valid),       32'h0);
        chk("t1_tail",      32'(ccff_tail),       32'h0);
        $display("reset release checked");

        // load mux0 sel=3, others 0
        for (int k = 0; k < NP; k++) wsel[k] = 0;
        wsel[0] = 3;
        w = pack_w();
        load(w);
        chk("t2_valid", 32'(cfg_valid), 32'h1);
        for (int r = 0; r < 4; r++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("t2_ipin0", 32'(ipin_out[0]), 32'(chanx_right_in[4]));
            chk("t2_ipin5", 32'(ipin_out[5]), 32'(chanx_left_in[5]));
        end

        // short commit after 29 shifts, then one more shift and commit
        for (int k = 0; k < NP; k++) wsel[k] = $urandom_range(0, MS - 1);
        wsel[0] = 1;
        w = pack_w();
        $display("short commit cfg=%h", w);
        for (int i = CB - 1; i >= 1; i--) step(w[i], 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_err_pulse", 32'(cfg_err), 32'h1);
        chk("t3_old_ipin0", 32'(ipin_out[0]), 32'(chanx_right_in[4]));
        step(1'b0, 1'b0, 1'b0);
        chk("t3_err_clear", 32'(cfg_err), 32'h0);
        step(w[0], 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_accept_err", 32'(cfg_err), 32'h0);
        chk("t3_new_ipin0", 32'(ipin_out[0]), 32'(chanx_right_in[0]));
        step(1'b0, 1'b0, 1'b1);
        chk("t3_held_commit", 32'(cfg_err), 32'h1);

        // glitch-free reprogram: the model checks every cycle of the stream
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < NP; k++) wsel[k] = $urandom_range(0, MS - 1);
            load(pack_w());
        end

        // illegal select, then repaired
        for (int k = 0; k < NP; k++) wsel[k] = 0;
        wsel[2] = 7;
        load(pack_w());
        chk("t5_ipin2_zero", 32'(ipin_out[2]), 32'h0);
        chk("t5_sel_err",    32'(sel_err),     32'h1);
        wsel[2] = 2;
        load(pack_w());
        chk("t5_sel_err_clr", 32'(sel_err),     32'h0);
        chk("t5_ipin2",       32'(ipin_out[2]), 32'(chanx_left_in[6]));

        // random traffic: shifts, commits, collisions
        $display("random traffic start");
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end

        // daisy chain: single 1 followed by zeros
        for (int k = 0; k < NP; k++) wsel[k] = $urandom_range(0, MS - 1);
        load(pack_w());
        $display("daisy chain pattern");
        for (int i = 1; i <= CB; i++) begin
            step((i == 1), 1'b1, 1'b0);
            if (i == CB) chk("t6_tail_30", 32'(ccff_tail), 32'h1);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("t6_tail_31", 32'(ccff_tail), 32'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0);

        // reset in the middle of a shift
        @(negedge clk);
        ccff_en = 1'b1; ccff_head = 1'b1; ccff_commit = 1'b0;
        #2;
        prog_reset = 1'b1;
        #1;
        chk("t6_rst_ipin",  32'(ipin_out),  32'h0);
        chk("t6_rst_tail",  32'(ccff_tail), 32'h0);
        chk("t6_rst_valid", 32'(cfg_valid), 32'h0);
        chk("t6_rst_selerr",32'(sel_err),   32'h0);
        chk("t6_rst_err",   32'(cfg_err),   32'h0);
        @(posedge clk);
        model_update();
        #1;
        compare();
        prog_reset = 1'b0;
        $display("reset mid-shift checked");
        step(1'b0, 1'b0, 1'b1);
        chk("t6_post_rst_commit", 32'(cfg_err), 32'h1);
        for (int k = 0; k < NP; k++) wsel[k] = $urandom_range(0, MS - 1);
        load(pack_w());
        chk("t6_reload_valid", 32'(cfg_valid), 32'h1);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
